keypad_scan_ctrl: RTL
=====================

# keypad_scan_ctrl

Sequencing controller for the calculator's 4x4 matrix keypad. It drives the one-hot column strobe, samples and synchronises the row lines, and debounces a complete scan of the matrix. It emits exactly one key event per debounced press to the calculator FSM over a valid/ready handshake. It sits between the keypad pins and the calculator input decoder.

## Interface
- SCAN_DIV, default 1000: clock cycles each column stays driven (dwell); minimum 4.
- DEBOUNCE_SCANS, default 4: number of consecutive identical full scans needed to accept a press or a release; minimum 2.
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  scanning enabled; low parks the controller.
- filas  input  4  raw keypad row lines, active-high, asynchronous.
- columnas  output  4  one-hot column strobe, active-high.
- key_code  output  4  accepted key, {row_idx[1:0], col_idx[1:0]}.
- key_valid  output  1  key_code holds an unconsumed event.
- key_ready  input  1  consumer accepts the event when key_valid is high.
- key_error  output  1  1-cycle pulse: a scan saw more than one key.
- overflow  output  1  1-cycle pulse: an accepted event was dropped.

## Operation
- Reset values: columnas=0000, key_code=0, key_valid=0, key_error=0, overflow=0, state IDLE, all counters 0.
- filas passes through a 2-flop synchroniser before any use.
- The FSM has four states: IDLE, SCAN, DEBOUNCE, WAIT_RELEASE.
- IDLE: columnas=0000. If enable=1, go to SCAN on the next cycle with columnas=0001 and the dwell counter at 0.
- Scanning (SCAN, DEBOUNCE, WAIT_RELEASE):
  - columnas rotates 0001->0010->0100->1000->0001. Each column is held SCAN_DIV cycles.
  - The synchronised rows are sampled on the last dwell cycle of each column.
  - A full scan ends on the last dwell cycle of column 3.
- Scan result, evaluated at the end of each scan:
  - EMPTY: no row bit set in any column.
  - SINGLE: exactly one row bit set in exactly one column. This yields candidate {row, col}.
  - MULTI: anything else.
- SCAN: a SINGLE result loads the candidate, sets the stable count to 1 and moves to DEBOUNCE. An EMPTY result stays in SCAN.
- DEBOUNCE:
  - A SINGLE result with the same candidate increments the count. When the count reaches DEBOUNCE_SCANS, the event is pushed and the FSM moves to WAIT_RELEASE.
  - A SINGLE result with a different candidate reloads the candidate with count 1.
  - An EMPTY result returns to SCAN.
- MULTI in SCAN or DEBOUNCE pulses key_error, clears the count and returns to SCAN.
- WAIT_RELEASE:
  - Requires DEBOUNCE_SCANS consecutive EMPTY scans before returning to SCAN.
  - Any non-EMPTY scan resets the empty count.
  - No key_error is raised in this state.
- enable falling in any state:
  - Next cycle: state IDLE, columnas=0000, counters cleared.
  - Buffered events and key_valid are kept; the handshake continues.
- Handshake:
  - key_code and key_valid are stable while key_valid=1 and key_ready=0.
  - A transfer happens on a cycle where key_valid=1 and key_ready=1.
  - key_ready is ignored while key_valid=0.

## Timing
- Scan period is 4*SCAN_DIV cycles.
- Press to key_valid:
  - The row input must be present at the synchroniser input 2 cycles before the sample edge.
  - key_valid rises 1 cycle after the end of the scan that reaches DEBOUNCE_SCANS.
- Minimum press-to-event time is DEBOUNCE_SCANS full scans.
- key_error and overflow pulse 1 cycle after the end of the offending scan.
- Push and pop on the same cycle are both performed.
- Reset asserted mid-scan or mid-handshake:
  - All outputs return to their reset values immediately (asynchronous).
  - Buffered events are discarded.

## Configuration
- KEYPAD_FIFO_EN defined:
  - Events go into a 4-entry FIFO; key_code/key_valid show the head entry.
  - A push when the FIFO is full, with no pop in the same cycle, drops the new event and pulses overflow.
  - A push to a full FIFO with a pop in the same cycle is accepted.
- KEYPAD_FIFO_EN undefined:
  - A single holding register is used.
  - A push while key_valid=1 and key_ready=0 drops the new event and pulses overflow.
  - A push on the same cycle as a transfer loads the new event, and key_valid stays 1.

## Test plan
- All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=3, giving a 16-cycle scan.
- Reset and rotation: reset, then enable=1 -> columnas 0000 during reset, then 0001, 0010, 0100, 1000 each held 4 cycles, repeating with period 16.
- Clean press: row 2 high while column 1 is strobed, held for 5 scans, key_ready=1 -> exactly one key_valid pulse with key_code=4'b1001, arriving 1 cycle after the end of the 3rd scan. Releasing the key produces no further event.
- Bounce: key 4'b0110 present for 2 scans, absent for 1, present for 3 -> a single event, at the end of the 3rd scan of the final burst.
- Multi-key: keys {0,0} and {3,3} pressed together -> key_error pulses once per scan, no event, FSM stays in SCAN. Releasing {3,3} while keeping {0,0} -> event 4'b0000 after 3 scans.
- Backpressure (FIFO off): key_ready=0, two keys pressed and released in sequence -> the first event is held stable, the second is dropped with overflow pulsed once. With KEYPAD_FIFO_EN, five events -> four are buffered and delivered in order, overflow pulses for the fifth.
- enable/reset mid-operation:
  - enable=0 mid-debounce -> columnas=0000 on the next cycle and no event.
  - Re-enabling -> restarts at 0001 with a fresh debounce.
  - reset with key_valid=1 -> key_valid=0 asynchronously.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column strobe, row synchroniser, full-scan debounce, valid/ready event output.
// Optional: define KEYPAD_FIFO_EN for a 4-entry event FIFO instead of a single holding register.
module keypad_scan_ctrl #(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] filas,
    output logic [3:0] columnas,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_error,
    output logic       overflow
);

    localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_SCANS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DEBOUNCE, WAIT_RELEASE} state_t;

    state_t        state, state_n;
    logic [3:0]    sync1, sync2;
    logic [DW-1:0] dwell, dwell_n;
    logic [1:0]    col_idx, col_idx_n;
    logic [3:0]    columnas_n;
    logic [11:0]   row_map, row_map_n;
    logic [3:0]    cand, cand_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          error_n;
    logic          push;
    logic          pop;

    logic [15:0]   full_map;
    logic [4:0]    ones;
    logic [3:0]    hit_idx;
    logic [3:0]    hit_code;
    logic          scan_end, scan_empty, scan_single;

    // Whole-scan classification; map bit index is col*4+row.
    always_comb begin
        full_map = {sync2, row_map};
        ones     = '0;
        hit_idx  = '0;
        for (int i = 0; i < 16; i++) begin
            if (full_map[i]) begin
                ones    = ones + 5'd1;
                hit_idx = 4'(i);
            end
        end
        hit_code    = {hit_idx[1:0], hit_idx[3:2]};
        scan_empty  = (ones == 5'd0);
        scan_single = (ones == 5'd1);
        scan_end    = (state != IDLE) && (dwell == DWELL_LAST) && (col_idx == 2'd3);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            state    <= IDLE;
            dwell    <= '0;
            col_idx  <= '0;
            columnas <= '0;
            row_map  <= '0;
            cand     <= '0;
            cnt      <= '0;
            key_error <= 1'b0;
        end else begin
            sync1    <= filas;
            sync2    <= sync1;
            state    <= state_n;
            dwell    <= dwell_n;
            col_idx  <= col_idx_n;
            columnas <= columnas_n;
            row_map  <= row_map_n;
            cand     <= cand_n;
            cnt      <= cnt_n;
            key_error <= error_n;
        end
    end

    always_comb begin
        state_n    = state;
        dwell_n    = dwell;
        col_idx_n  = col_idx;
        columnas_n = columnas;
        row_map_n  = row_map;
        cand_n     = cand;
        cnt_n      = cnt;
        error_n    = 1'b0;
        push       = 1'b0;

        if (!enable) begin
            state_n    = IDLE;
            dwell_n    = '0;
            col_idx_n  = '0;
            columnas_n = '0;
            row_map_n  = '0;
            cand_n     = '0;
            cnt_n      = '0;
        end else if (state == IDLE) begin
            state_n    = SCAN;
            dwell_n    = '0;
            col_idx_n  = '0;
            columnas_n = 4'b0001;
        end else begin
            // Column dwell and rotation; rows are captured on the last dwell cycle.
            if (dwell == DWELL_LAST) begin
                dwell_n    = '0;
                col_idx_n  = 2'(col_idx + 2'd1);
                columnas_n = {columnas[2:0], columnas[3]};
                case (col_idx)
                    2'd0:    row_map_n[3:0]  = sync2;
                    2'd1:    row_map_n[7:4]  = sync2;
                    2'd2:    row_map_n[11:8] = sync2;
                    default: ;
                endcase
            end else begin
                dwell_n = DW'(dwell + DW'(1));
            end

            if (scan_end) begin
                case (state)
                    SCAN: begin
                        if (scan_single) begin
                            cand_n  = hit_code;
                            cnt_n   = CW'(1);
                            state_n = DEBOUNCE;
                        end else if (!scan_empty) begin
                            error_n = 1'b1;
                            cnt_n   = '0;
                        end
                    end
                    DEBOUNCE: begin
                        if (scan_single) begin
                            if (hit_code == cand) begin
                                if (cnt == CNT_LAST) begin
                                    push    = 1'b1;
                                    cnt_n   = '0;
                                    state_n = WAIT_RELEASE;
                                end else begin
                                    cnt_n = CW'(cnt + CW'(1));
                                end
                            end else begin
                                cand_n = hit_code;
                                cnt_n  = CW'(1);
                            end
                        end else if (scan_empty) begin
                            cnt_n   = '0;
                            state_n = SCAN;
                        end else begin
                            error_n = 1'b1;
                            cnt_n   = '0;
                            state_n = SCAN;
                        end
                    end
                    WAIT_RELEASE: begin
                        if (!scan_empty) begin
                            cnt_n = '0;
                        end else if (cnt == CNT_LAST) begin
                            cnt_n   = '0;
                            state_n = SCAN;
                        end else begin
                            cnt_n = CW'(cnt + CW'(1));
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign pop = key_valid && key_ready;

`ifdef KEYPAD_FIFO_EN
    logic [3:0] fifo_mem [4];
    logic [1:0] rd_ptr, wr_ptr;
    logic [2:0] fill, fill_n;
    logic       accept;

    always_comb begin
        accept = push && ((fill != 3'd4) || pop);
        fill_n = 3'(fill + {2'b00, accept} - {2'b00, pop});
    end

    // key_code is kept as a registered copy of the head entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            fill      <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (accept) begin
                fifo_mem[wr_ptr] <= cand;
                wr_ptr           <= 2'(wr_ptr + 2'd1);
            end
            if (pop) rd_ptr <= 2'(rd_ptr + 2'd1);
            fill      <= fill_n;
            key_valid <= (fill_n != 3'd0);
            overflow  <= push && !accept;
            if (accept && (pop ? (fill == 3'd1) : (fill == 3'd0))) begin
                key_code <= cand;
            end else if (pop && (fill_n != 3'd0)) begin
                key_code <= fifo_mem[2'(rd_ptr + 2'd1)];
            end
        end
    end
`else
    // Single holding register; a push only lands when the slot is free or being drained.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (push) begin
                if (!key_valid || pop) begin
                    key_code  <= cand;
                    key_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (pop) begin
                key_valid <= 1'b0;
            end
        end
    end
`endif

endmodule
